// File: rtl/fifo_ctrl_status_if.sv
// Handshake and status bundle between a FIFO producer/consumer and fifo_ctrl_status.
// The master side drives requests; the slave side (the controller) returns enables, pointers and status.
interface fifo_ctrl_status_if #(
    parameter int AddrBits = 4
);
    logic                clr_i;
    logic                wr_i;
    logic                rd_i;
    logic                wr_en_o;
    logic                rd_en_o;
    logic [AddrBits-1:0] w_addr_o;
    logic [AddrBits-1:0] r_addr_o;
    logic [AddrBits:0]   count_o;
    logic                full_o;
    logic                empty_o;
    logic                almost_full_o;
    logic                almost_empty_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output clr_i, wr_i, rd_i,
        input  wr_en_o, rd_en_o, w_addr_o, r_addr_o, count_o,
        input  full_o, empty_o, almost_full_o, almost_empty_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, rd_i,
        output wr_en_o, rd_en_o, w_addr_o, r_addr_o, count_o,
        output full_o, empty_o, almost_full_o, almost_empty_o,
        output overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_ctrl_status.sv
// Pointer, occupancy and status controller for a 2**AddrBits-entry register-file FIFO.
// Define FIFO_CTRL_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module fifo_ctrl_status #(
    parameter int AddrBits       = 4,
    parameter int AlmostFullThr  = 2**AddrBits - 1,
    parameter int AlmostEmptyThr = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fifo_ctrl_status_if.slave  bus
);
    localparam int CntW  = AddrBits + 1;
    localparam int Depth = 2**AddrBits;

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);
    localparam logic [CntW-1:0] AfThr  = CntW'(AlmostFullThr);
    localparam logic [CntW-1:0] AeThr  = CntW'(AlmostEmptyThr);

    logic [AddrBits-1:0] w_addr_q;
    logic [AddrBits-1:0] r_addr_q;
    logic [CntW-1:0]     count_q;
    logic [CntW-1:0]     count_d;
    logic                full_q;
    logic                empty_q;
    logic                almost_full_q;
    logic                almost_empty_q;
    logic                wr_en;
    logic                rd_en;

    // A write into a full FIFO is still accepted when a read frees the slot at the same edge.
    assign wr_en = bus.wr_i & ~bus.clr_i & (~full_q | bus.rd_i);
    assign rd_en = bus.rd_i & ~bus.clr_i & ~empty_q;

    assign count_d = count_q + CntW'(wr_en) - CntW'(rd_en);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clr_i) begin
            w_addr_q       <= '0;
            r_addr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            if (wr_en) w_addr_q <= w_addr_q + AddrBits'(1);
            if (rd_en) r_addr_q <= r_addr_q + AddrBits'(1);
            count_q        <= count_d;
            full_q         <= (count_d == DepthC);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= AfThr);
            almost_empty_q <= (count_d <= AeThr);
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Rejected requests latch an error until reset or flush; requests during a flush are ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.clr_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_i && !wr_en) overflow_q  <= 1'b1;
            if (bus.rd_i && !rd_en) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;
`else
    assign bus.overflow_o  = 1'b0;
    assign bus.underflow_o = 1'b0;
`endif

    assign bus.wr_en_o        = wr_en;
    assign bus.rd_en_o        = rd_en;
    assign bus.w_addr_o       = w_addr_q;
    assign bus.r_addr_o       = r_addr_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_full_o  = almost_full_q;
    assign bus.almost_empty_o = almost_empty_q;
endmodule

// File: tb/tb_fifo_ctrl_status.sv
// Directed self-checking bench for fifo_ctrl_status with DEPTH=4, almost-full 3, almost-empty 1.
// Expected error flags follow FIFO_CTRL_ERR_FLAGS_EN so the bench suits both builds.
module tb_fifo_ctrl_status;
    localparam int AddrBits = 2;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    fifo_ctrl_status_if #(.AddrBits(AddrBits)) bus ();

    fifo_ctrl_status #(
        .AddrBits      (AddrBits),
        .AlmostFullThr (3),
        .AlmostEmptyThr(1)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change one time unit after the edge; enables are sampled a unit later.
    task automatic applyStimulus(input logic wr, input logic rd, input logic clr);
        bus.wr_i  = wr;
        bus.rd_i  = rd;
        bus.clr_i = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkEnables(input string tag, input logic wr_en, input logic rd_en);
        checkOutput({tag, ".wr_en"}, 32'(bus.wr_en_o), 32'(wr_en));
        checkOutput({tag, ".rd_en"}, 32'(bus.rd_en_o), 32'(rd_en));
    endtask

    task automatic checkStatus(input string tag, input int cnt, input int wa, input int ra,
                               input logic ov, input logic un);
        checkOutput({tag, ".count"},  32'(bus.count_o),        32'(cnt));
        checkOutput({tag, ".w_addr"}, 32'(bus.w_addr_o),       32'(wa));
        checkOutput({tag, ".r_addr"}, 32'(bus.r_addr_o),       32'(ra));
        checkOutput({tag, ".full"},   32'(bus.full_o),         32'(cnt == 4));
        checkOutput({tag, ".empty"},  32'(bus.empty_o),        32'(cnt == 0));
        checkOutput({tag, ".afull"},  32'(bus.almost_full_o),  32'(cnt >= 3));
        checkOutput({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(cnt <= 1));
        checkOutput({tag, ".ovf"},    32'(bus.overflow_o),     32'(ov & ErrEn));
        checkOutput({tag, ".unf"},    32'(bus.underflow_o),    32'(un & ErrEn));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        bus.wr_i  = 1'b0;
        bus.rd_i  = 1'b0;
        bus.clr_i = 1'b0;

        // Reset state
        tick();
        tick();
        checkStatus("reset", 0, 0, 0, 1'b0, 1'b0);
        rst_ni = 1'b1;

        // Read when empty, then flush away the error
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkEnables("rd_empty", 1'b0, 1'b0);
        tick();
        checkStatus("rd_empty", 0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkEnables("clr_rd", 1'b0, 1'b0);
        tick();
        checkStatus("clr_rd", 0, 0, 0, 1'b0, 1'b0);

        // Fill
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkEnables($sformatf("fill%0d", i), 1'b1, 1'b0);
            tick();
            checkStatus($sformatf("fill%0d", i), i, i % 4, 0, 1'b0, 1'b0);
        end

        // Write when full: rejected, overflow sticks
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEnables("wr_full", 1'b0, 1'b0);
        tick();
        checkStatus("wr_full", 4, 0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkStatus("ovf_sticky", 4, 0, 0, 1'b1, 1'b0);

        // Drain
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkEnables($sformatf("drain%0d", i), 1'b0, 1'b1);
            tick();
            checkStatus($sformatf("drain%0d", i), 4 - i, 0, i % 4, 1'b1, 1'b0);
        end

        // Simultaneous when empty: only the write goes in
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEnables("both_empty", 1'b1, 1'b0);
        tick();
        checkStatus("both_empty", 1, 1, 0, 1'b1, 1'b1);

        // Refill to full
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            tick();
        end
        checkStatus("refill", 4, 0, 0, 1'b1, 1'b1);

        // Simultaneous when full: both accepted, count unchanged
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkEnables("both_full", 1'b1, 1'b1);
        tick();
        checkStatus("both_full", 4, 1, 1, 1'b1, 1'b1);

        // Down to 3, then flush with a write pending
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkStatus("pre_clr", 3, 1, 2, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkEnables("clr_wr", 1'b0, 1'b0);
        tick();
        checkStatus("clr_wr", 0, 0, 0, 1'b0, 1'b0);

        // Reset mid-operation at count 2 with an error flag set
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkStatus("pre_rst", 2, 2, 0, 1'b0, 1'b1);
        rst_ni = 1'b0;
        tick();
        checkStatus("mid_rst", 0, 0, 0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkStatus("post_rst", 0, 0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
